// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state type and counter sizing for the iterative divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_SIZE = 32;

  // Counter must hold the full step count, hence the +1.
  function automatic int cnt_width(input int data_size);
    return $clog2(data_size + 1);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DEFAULT_DATA_SIZE);

endpackage

// File: rtl/divider.sv
// rtl/divider.sv - radix-2 restoring divider, one quotient bit per cycle, signed or unsigned
module divider
  import divider_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sign,
  input  logic                 flush,
  input  logic [DATA_SIZE-1:0] data_1,
  input  logic [DATA_SIZE-1:0] data_2,
  output logic                 busy,
  output logic                 ready,
  output logic [DATA_SIZE-1:0] quotient,
  output logic [DATA_SIZE-1:0] remainder
);

  localparam int CW = cnt_width(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_SIZE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [DATA_SIZE-1:0] rem_q;
  logic [DATA_SIZE-1:0] quo_q;
  logic [DATA_SIZE-1:0] dvs_q;
  logic                 q_neg;
  logic                 r_neg;

  logic                 accept;
  logic                 a_neg;
  logic                 b_neg;
  logic                 dvs_zero;
  logic                 step_ok;
  logic [DATA_SIZE-1:0] a_abs;
  logic [DATA_SIZE-1:0] b_abs;
  logic [DATA_SIZE-1:0] rem_nxt;
  logic [DATA_SIZE-1:0] quo_nxt;
  logic [DATA_SIZE:0]   trial;

  assign accept   = (state == IDLE) && enable && !flush;
  assign a_neg    = sign & data_1[DATA_SIZE-1];
  assign b_neg    = sign & data_2[DATA_SIZE-1];
  assign a_abs    = a_neg ? -data_1 : data_1;
  assign b_abs    = b_neg ? -data_2 : data_2;
  assign dvs_zero = (data_2 == '0);

  // quo_q starts as the dividend and shifts its MSB into the partial remainder
  // while quotient bits fill in from the bottom.
  assign trial   = {rem_q, quo_q[DATA_SIZE-1]} - {1'b0, dvs_q};
  assign step_ok = ~trial[DATA_SIZE];
  assign rem_nxt = step_ok ? trial[DATA_SIZE-1:0] : {rem_q[DATA_SIZE-2:0], quo_q[DATA_SIZE-1]};
  assign quo_nxt = {quo_q[DATA_SIZE-2:0], step_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    ready     = (state == DONE);
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = dvs_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt   <= CNT_LOAD;
      rem_q <= '0;
      quo_q <= a_abs;
      dvs_q <= b_abs;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      // Zero divisor bypasses CALC, so its result is produced right here.
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= data_1;
      end
    end else if ((state == CALC) && !flush) begin
      cnt   <= cnt - CNT_ONE;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (cnt == CNT_ONE) begin
        quotient  <= q_neg ? -quo_nxt : quo_nxt;
        remainder <= r_neg ? -rem_nxt : rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for divider: latency, results, flush, reset, ignored requests
module tb_divider;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        sign;
  logic        flush;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic        busy;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  logic [31:0] sb_r[$];
  logic [31:0] last_q;
  logic [31:0] last_r;

  divider #(.DATA_SIZE(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sign      (sign),
    .flush     (flush),
    .data_1    (data_1),
    .data_2    (data_2),
    .busy      (busy),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts and ends just after a falling edge; the request is driven in cycle 0.
  // poke: cycle in which a stray enable is driven (99 = during the DONE cycle, 0 = none).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int poke);
    logic [31:0] eq, er, oq, orr;
    int lat, exp_lat, busy_gap;
    bit seen;
    model(a, b, s, eq, er);
    sb_q.push_back(eq);
    sb_r.push_back(er);
    exp_lat  = (b == 32'd0) ? 1 : 33;
    enable   = 1'b1;
    data_1   = a;
    data_2   = b;
    sign     = s;
    lat      = 0;
    busy_gap = 0;
    seen     = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready) seen = 1;
      else if (!busy) busy_gap++;
      if (lat == 1 && exp_lat != 1) begin
        check_eq({tag, "_hold_q"}, quotient, last_q);
      end
      data_1 = $urandom;
      data_2 = $urandom;
      sign   = ($urandom_range(0, 1) != 0);
      enable = (lat == poke) || (seen && poke == 99);
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_busy_gap"}, busy_gap, 0);
    oq  = sb_q.pop_front();
    orr = sb_r.pop_front();
    check_eq({tag, "_quotient"}, quotient, oq);
    check_eq({tag, "_remainder"}, remainder, orr);
    last_q = oq;
    last_r = orr;
    @(negedge clk);
    enable = 1'b0;
    check_eq({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_held_q"}, quotient, last_q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    int ready_seen;
    rst    = 1'b1;
    enable = 1'b0;
    sign   = 1'b0;
    flush  = 1'b0;
    data_1 = 32'd0;
    data_2 = 32'd0;
    last_q = 32'd0;
    last_r = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_quotient", quotient, 32'd0);
    check_eq("rst_remainder", remainder, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("unsigned_100_7", 32'd100, 32'd7, 1'b0, 0);
    run_div("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div("divzero_u", 32'd5, 32'd0, 1'b0, 0);
    run_div("divzero_s", 32'd5, 32'd0, 1'b1, 0);
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div("poke_calc", 32'd1000, 32'd33, 1'b0, 5);
    run_div("poke_done", 32'd12345, 32'd10, 1'b0, 99);
    run_div("signed_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_div("max_by_one", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_div("small_by_big", 32'd3, 32'hFFFF_FFF0, 1'b0, 0);

    // Flush at cycle 10, then a fresh request in cycle 11.
    enable = 1'b1;
    data_1 = 32'd100;
    data_2 = 32'd7;
    sign   = 1'b0;
    ready_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      enable = 1'b0;
      if (ready) ready_seen++;
      flush = (k == 10);
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_no_ready", ready_seen + 32'(ready), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_q_kept", quotient, last_q);
    check_eq("flush_r_kept", remainder, last_r);
    run_div("after_flush_9_3", 32'd9, 32'd3, 1'b0, 0);

    // Flush beats enable in IDLE.
    flush  = 1'b1;
    enable = 1'b1;
    data_1 = 32'd50;
    data_2 = 32'd5;
    @(negedge clk);
    flush  = 1'b0;
    enable = 1'b0;
    check_eq("flush_wins_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("flush_wins_ready", 32'(ready), 32'd0);

    // Reset in cycle 20 of an operation.
    enable = 1'b1;
    data_1 = 32'd100;
    data_2 = 32'd7;
    ready_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      enable = 1'b0;
      if (ready) ready_seen++;
      rst = (k == 20);
    end
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_no_ready", ready_seen + 32'(ready), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_quotient", quotient, 32'd0);
    check_eq("midrst_remainder", remainder, 32'd0);
    last_q = 32'd0;
    last_r = 32'd0;
    run_div("after_rst_100_7", 32'd100, 32'd7, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      run_div("random", ra, rb, (i % 2) == 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DATA_SIZE, default 32; operand and result width in bits.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  request a new division; sampled only in IDLE.
REQ-005 sign  input  1  1 = signed two's-complement operands, 0 = unsigned.
REQ-006 flush  input  1  abort any operation in progress.
REQ-007 data_1  input  DATA_SIZE  dividend.
REQ-008 data_2  input  DATA_SIZE  divisor.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 ready  output  1  one-cycle pulse marking valid quotient and remainder.
REQ-011 quotient  output  DATA_SIZE  division quotient.
REQ-012 remainder  output  DATA_SIZE  division remainder.

Function
REQ-013 The block SHALL implement an iterative radix-2 restoring divider with states IDLE, CALC and DONE.
REQ-014 In IDLE with enable=1 and flush=0, the block SHALL latch the absolute values of the operands (negated when sign=1 and MSB=1), the operand sign info and the divisor-zero flag, then enter CALC.
REQ-015 CALC SHALL execute exactly one shift/subtract step per cycle for DATA_SIZE cycles, then enter DONE.
REQ-016 DONE SHALL last exactly one cycle with ready=1, then return to IDLE.
REQ-017 For a nonzero divisor, ready SHALL assert DATA_SIZE+1 cycles after the cycle in which enable was accepted (cycle 33 for DATA_SIZE=32).
REQ-018 A zero divisor SHALL skip CALC: IDLE->DONE, ready at cycle 1, quotient all-ones, remainder = data_1 unmodified, for both signed and unsigned operation.
REQ-019 For signed operation, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign (truncating division).
REQ-020 Signed overflow (most-negative value / -1) SHALL yield quotient = most-negative value and remainder = 0, with no special-case path.
REQ-021 quotient and remainder SHALL be registered, valid from the ready cycle, and held until the next enable is accepted.
REQ-022 enable while busy=1, including in DONE, SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge with no ready pulse, and SHALL leave quotient and remainder unchanged.
REQ-024 flush and enable together in IDLE: flush SHALL win and no operation SHALL start.
REQ-025 Operand inputs SHALL be sampled only at acceptance; later changes to data_1, data_2 or sign SHALL have no effect.

Reset
REQ-026 rst=1 SHALL force state IDLE, busy=0, ready=0, quotient=0, remainder=0 and clear all iteration registers at the next edge.
REQ-027 rst asserted mid-operation SHALL abandon the operation with no ready pulse, and SHALL take priority over flush and enable.

Structure
REQ-028 A shared package SHALL hold the state enum typedef (IDLE, CALC, DONE) and the iteration-count width constant, as $clog2(DATA_SIZE+1).
REQ-029 The design SHALL be a single module with no sub-modules, using one iteration counter, a partial-remainder register and a quotient shift register.

Verification
REQ-030 Unsigned: data_1=100, data_2=7, sign=0 -> ready at cycle 33, quotient=14, remainder=2, busy high in cycles 1-33.
REQ-031 Signed: data_1=0xFFFFFFF9 (-7), data_2=2, sign=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-032 Divide by zero: data_1=5, data_2=0 (sign 0 and 1) -> ready at cycle 1, quotient=0xFFFFFFFF, remainder=5.
REQ-033 Overflow: data_1=0x80000000, data_2=0xFFFFFFFF, sign=1 -> quotient=0x80000000, remainder=0 at cycle 33.
REQ-034 Abort, reissue and ignored requests:
- flush at cycle 10 of 100/7 -> no ready, busy=0 in cycle 11.
- A new 9/3 request accepted in cycle 11 -> quotient=3, remainder=0.
- enable pulsed during CALC -> ignored.
REQ-035 Reset: rst at cycle 20 of an operation -> outputs zero and busy=0 next cycle, no ready pulse, and the next request completes correctly.
